// File: rtl/serial_capture_5b_pkg.sv
// Shared definitions for the serial capture receive block.
// Holds the detector state encoding and shift-register / fill sizing.
// Imported by the detector sub-module and the top.
package serial_capture_5b_pkg;

  // Detector states, 3-bit encoding, IDLE=0 .. S1011=4
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S10   = 3'd2,
    ST_S101  = 3'd3,
    ST_S1011 = 3'd4
  } det_state_t;

  // Number of taps in the capture shift register
  localparam int SR_DEPTH = 5;

  // Fill counter saturation point: taps all hold real data once reached
  localparam int FILL_MAX = 5;
  localparam int FILL_W   = 3;

endpackage

// File: rtl/serial_capture_5b_seq_det.sv
// Overlapping "1011" Moore sequence detector.
// det is high the cycle after the edge that samples the final 1.
// det_rise flags (combinationally) that the coming edge enters S1011.
module seq_det_1011
  import serial_capture_5b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic det,
  output logic det_rise
);

  det_state_t state;
  det_state_t state_nxt;

  // State register; reset returns to IDLE and discards any partial match
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: on a mismatch fall back to the longest matching suffix
  always_comb begin
    state_nxt = ST_IDLE;
    unique case (state)
      ST_IDLE:  state_nxt = din ? ST_S1    : ST_IDLE;
      ST_S1:    state_nxt = din ? ST_S1    : ST_S10;
      ST_S10:   state_nxt = din ? ST_S101  : ST_IDLE;
      ST_S101:  state_nxt = din ? ST_S1011 : ST_S10;
      ST_S1011: state_nxt = din ? ST_S1    : ST_S10;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: Moore detect flag plus an entry strobe for the counter
  always_comb begin
    det      = (state == ST_S1011);
    det_rise = (state_nxt == ST_S1011);
  end

endmodule

// File: rtl/serial_capture_5b.sv
// Serial line receiver: 5-tap capture register, "1011" detector and run monitor.
// Latency S_OR->X one edge, S_OR->M five edges, detect pulse one edge after final 1.
// No backpressure: S_OR is sampled unconditionally every rising edge.
module serial_capture_5b
  import serial_capture_5b_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MIN_RUN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_OR,
  output logic             X,
  output logic             Y,
  output logic             Z,
  output logic             K,
  output logic             M,
  output logic             valid,
  output logic             det,
  output logic [CNT_W-1:0] det_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             run_ok
);

  // Bit 0 is the newest sample, bit SR_DEPTH-1 the oldest
  logic [SR_DEPTH-1:0] shreg;
  logic [FILL_W-1:0]   fill;
  logic                det_rise;

  localparam logic [FILL_W-1:0] FILL_TOP = FILL_W'(FILL_MAX);
  localparam logic [CNT_W-1:0]  CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  RUN_MIN  = CNT_W'(MIN_RUN);

  seq_det_1011 u_det (
    .clk      (clk),
    .rst      (rst),
    .din      (S_OR),
    .det      (det),
    .det_rise (det_rise)
  );

  // Capture shift register: newest bit enters at tap 0
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else begin
      shreg <= {shreg[SR_DEPTH-2:0], S_OR};
    end
  end

  // Fill counter: counts edges since reset until every tap is real data
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
    end else if (fill != FILL_TOP) begin
      fill <= fill + 1'b1;
    end
  end

  // Detection counter: bumps on the edge entering S1011, holds at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      det_cnt <= '0;
    end else if (det_rise && (det_cnt != CNT_TOP)) begin
      det_cnt <= det_cnt + 1'b1;
    end
  end

  // Consecutive-ones run length: any zero clears, ones count up and saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len <= '0;
    end else if (!S_OR) begin
      run_len <= '0;
    end else if (run_len != CNT_TOP) begin
      run_len <= run_len + 1'b1;
    end
  end

  // Output decode: taps, fill status and the run threshold compare
  always_comb begin
    X      = shreg[0];
    Y      = shreg[1];
    Z      = shreg[2];
    K      = shreg[3];
    M      = shreg[4];
    valid  = (fill == FILL_TOP);
    run_ok = (run_len >= RUN_MIN);
  end

endmodule

// File: tb/tb_serial_capture_5b.sv
// Directed bench for serial_capture_5b with a reference model and scoreboard.
// Each step drives S_OR/rst, pushes the model's expected post-edge outputs,
// then pops and compares them against the DUT one time unit after the edge.
module tb_serial_capture_5b;

  logic       clk;
  logic       rst;
  logic       S_OR;
  logic       X, Y, Z, K, M;
  logic       valid;
  logic       det;
  logic [3:0] det_cnt;
  logic [3:0] run_len;
  logic       run_ok;

  int checks;
  int errors;

  typedef struct packed {
    logic [4:0] taps;   // {X,Y,Z,K,M}
    logic       valid;
    logic       det;
    logic [3:0] cnt;
    logic [3:0] run;
    logic       ok;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [4:0] m_taps;
  int         m_fill;
  logic [3:0] m_win;
  int         m_cnt;
  int         m_run;

  serial_capture_5b #(.CNT_W(4), .MIN_RUN(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .S_OR    (S_OR),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .K       (K),
    .M       (M),
    .valid   (valid),
    .det     (det),
    .det_cnt (det_cnt),
    .run_len (run_len),
    .run_ok  (run_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one edge worth of input, model it, then score the DUT outputs
  task automatic step(input logic b, input logic r);
    exp_t e;
    exp_t got;
    S_OR = b;
    rst  = r;
    if (r) begin
      m_taps = '0;
      m_fill = 0;
      m_win  = '0;
      m_cnt  = 0;
      m_run  = 0;
      e.det  = 1'b0;
    end else begin
      m_taps = {b, m_taps[4:1]};
      if (m_fill < 5) m_fill++;
      m_win = {m_win[2:0], b};
      e.det = (m_win == 4'b1011);
      if (e.det && m_cnt < 15) m_cnt++;
      if (b) begin
        if (m_run < 15) m_run++;
      end else begin
        m_run = 0;
      end
    end
    e.taps  = m_taps;
    e.valid = (m_fill == 5);
    e.cnt   = 4'(m_cnt);
    e.run   = 4'(m_run);
    e.ok    = (m_run >= 3);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("taps",    {3'b0, X, Y, Z, K, M}, {3'b0, got.taps});
    chk("valid",   {7'b0, valid},         {7'b0, got.valid});
    chk("det",     {7'b0, det},           {7'b0, got.det});
    chk("det_cnt", {4'b0, det_cnt},       {4'b0, got.cnt});
    chk("run_len", {4'b0, run_len},       {4'b0, got.run});
    chk("run_ok",  {7'b0, run_ok},        {7'b0, got.ok});
  endtask

  task automatic drive_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    S_OR   = 1'b1;
    m_taps = '0;
    m_fill = 0;
    m_win  = '0;
    m_cnt  = 0;
    m_run  = 0;
    @(negedge clk);

    // Reset held two edges with S_OR high: everything stays zero
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("fsm_idle", {5'b0, dut.u_det.state}, 8'd0);

    // Fill and tap ordering: 1,0,1,1,0 -> taps 0,1,1,0,1, valid on edge 5
    drive_bits(32'b10110, 5);
    chk("taps_after_fill", {3'b0, X, Y, Z, K, M}, 8'b0000_1101);

    // Overlapping detection: 1,0,1,1,0,1,1 -> det after edges 4 and 7
    step(1'b0, 1'b1);
    drive_bits(32'b1011011, 7);
    chk("det_cnt_two", {4'b0, det_cnt}, 8'd2);

    // Run monitor: 1,1,1,1,0
    step(1'b0, 1'b1);
    drive_bits(32'b11110, 5);

    // Detection counter saturation: 1011 twenty times
    step(1'b0, 1'b1);
    for (int r = 0; r < 20; r++) drive_bits(32'b1011, 4);
    chk("det_cnt_sat", {4'b0, det_cnt}, 8'd15);

    // Long run of ones saturates run_len
    drive_bits(32'hFFFF_FFFF, 18);
    chk("run_len_sat", {4'b0, run_len}, 8'd15);

    // Reset mid-pattern discards the partial 101
    step(1'b0, 1'b1);
    drive_bits(32'b101, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("no_det_after_rst", {7'b0, det}, 8'd0);
    drive_bits(32'b00, 2);
    drive_bits(32'b1011, 4);
    chk("det_after_full", {7'b0, det}, 8'd1);
    chk("det_cnt_one", {4'b0, det_cnt}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
